// File: rtl/sync_fifo_param.sv
// Single-clock FIFO over a simple-dual-port RAM with registered read, optional
// first-word-fall-through output, occupancy-derived flags and sticky error bits.
module sync_fifo_param #(
    parameter int WIDTH_DATA    = 48,
    parameter int WIDTH_ADDR    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 252,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [WIDTH_DATA-1:0] i_WDATA,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [WIDTH_DATA-1:0] o_RDATA,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [WIDTH_ADDR:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    localparam int CW    = WIDTH_ADDR + 1;
    localparam int DEPTH = 1 << WIDTH_ADDR;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic [WIDTH_DATA-1:0] ram_q;
    logic                  ram_q_vld;
    logic [WIDTH_ADDR-1:0] wr_ptr;
    logic [WIDTH_ADDR-1:0] rd_ptr;
    logic [CW-1:0]         ram_words;

    logic          rd_acc;
    logic          wr_acc;
    logic          ovf_evt;
    logic          udf_evt;
    logic          fetch;
    logic          s1_move;
    logic          ram_q_vld_nxt;
    logic          empty_nxt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] ram_words_nxt;

    // Handshake: a read is taken when i_rd_en is high and o_empty is low; a write is
    // taken when i_wr_en is high and the FIFO is not full or a read is taken the same cycle.
    always_comb begin
        rd_acc  = i_rd_en & ~o_empty;
        wr_acc  = i_wr_en & (~o_full | rd_acc);
        ovf_evt = i_wr_en & o_full & ~rd_acc;
        udf_evt = i_rd_en & o_empty;

        // FWFT keeps the RAM register and the output register topped up from the RAM;
        // standard mode only reads the RAM on an accepted read.
        if (FWFT != 0) begin
            s1_move = ram_q_vld & (o_empty | rd_acc);
            fetch   = (ram_words != '0) & (~ram_q_vld | s1_move);
        end else begin
            s1_move = ram_q_vld;
            fetch   = rd_acc;
        end
        ram_q_vld_nxt = fetch | (ram_q_vld & ~s1_move);

        count_nxt = o_count;
        if (wr_acc && !rd_acc) begin
            count_nxt = o_count + ONE_C;
        end else if (!wr_acc && rd_acc) begin
            count_nxt = o_count - ONE_C;
        end

        ram_words_nxt = ram_words;
        if (wr_acc && !fetch) begin
            ram_words_nxt = ram_words + ONE_C;
        end else if (!wr_acc && fetch) begin
            ram_words_nxt = ram_words - ONE_C;
        end

        if (FWFT != 0) begin
            empty_nxt = ~(s1_move | (~o_empty & ~rd_acc));
        end else begin
            empty_nxt = (count_nxt == '0);
        end
    end

    // Read-before-write: when the pointers collide the RAM register sees the old word.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_WDATA;
        end
        if (fetch) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_words      <= '0;
            ram_q_vld      <= 1'b0;
            o_RDATA        <= '0;
            o_count        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_empty <= 1'b1;
            o_almost_full  <= 1'b0;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (s1_move) begin
                o_RDATA <= ram_q;
            end
            ram_words      <= ram_words_nxt;
            ram_q_vld      <= ram_q_vld_nxt;
            o_count        <= count_nxt;
            o_empty        <= empty_nxt;
            o_full         <= (count_nxt == DEPTH_C);
            o_almost_full  <= (count_nxt >= AFULL_C);
            o_almost_empty <= (count_nxt <= AEMPTY_C);

            // A new error in the same cycle outranks the clear.
            if (ovf_evt) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
            if (udf_evt) begin
                o_underflow <= 1'b1;
            end else if (i_clr_err) begin
                o_underflow <= 1'b0;
            end
        end
    end

    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst) o_count <= DEPTH_C);
    a_nonempty_count: assert property (@(posedge i_clk) disable iff (i_rst) !o_empty |-> o_count != '0);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT instance, each checked
// against a queue-based model of the FIFO rules every clock.
module tb_sync_fifo_param;
    localparam int WD    = 48;
    localparam int WA    = 8;
    localparam int DEPTH = 256;
    localparam int AF    = 252;
    localparam int AE    = 4;

    // clock / reset
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
    logic [WD-1:0] wd0 = '0;
    logic [WD-1:0] rdata0;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic [WA:0]   cnt0;

    logic          wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
    logic [WD-1:0] wd1 = '0;
    logic [WD-1:0] rdata1;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic [WA:0]   cnt1;

    sync_fifo_param #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .FWFT(0),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(wr0), .i_WDATA(wd0), .i_rd_en(rd0),
        .i_clr_err(clr0), .o_RDATA(rdata0), .o_full(full0), .o_empty(empty0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_count(cnt0),
        .o_overflow(ovf0), .o_underflow(udf0)
    );

    sync_fifo_param #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .FWFT(1),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(wr1), .i_WDATA(wd1), .i_rd_en(rd1),
        .i_clr_err(clr1), .o_RDATA(rdata1), .o_full(full1), .o_empty(empty1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_count(cnt1),
        .o_overflow(ovf1), .o_underflow(udf1)
    );

    int checks   = 0;
    int failures = 0;

    // scoreboard / reference model
    typedef struct {
        logic [WD-1:0] d;
        int            w;
    } ent_t;

    logic [WD-1:0] exp_q0[$];
    logic [WD-1:0] exp_rdata0 = '0;
    logic [WD-1:0] pend0_val  = '0;
    bit            pend0 = 1'b0, m0_ovf = 1'b0, m0_udf = 1'b0;

    ent_t exp_q1[$];
    int   last_pop1 = 0;
    int   edge_n    = 0;
    bit   m1_ovf = 1'b0, m1_udf = 1'b0;

    typedef struct {
        bit            wr;
        logic [WD-1:0] wd;
        bit            rd;
        bit            clr;
        int            cnt;
        bit            empty;
        bit            udf;
        bit            chk_rd;
        logic [WD-1:0] rdata;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WD-1:0];
    endfunction

    // FWFT head becomes visible two edges after its write, and never before the previous pop.
    function automatic bit m1_vis(input int e);
        int v;
        if (exp_q1.size() == 0) return 1'b0;
        v = exp_q1[0].w + 2;
        if (last_pop1 > v) v = last_pop1;
        return v <= e;
    endfunction

    task automatic model_edge();
        bit   e0, f0, ra0, wa0, e1, f1, ra1, wa1;
        ent_t ent;
        edge_n++;

        e0  = (exp_q0.size() == 0);
        f0  = (exp_q0.size() == DEPTH);
        ra0 = rd0 && !e0;
        wa0 = wr0 && (!f0 || ra0);
        if (pend0) exp_rdata0 = pend0_val;
        pend0 = ra0;
        if (ra0) pend0_val = exp_q0.pop_front();
        if (wa0) exp_q0.push_back(wd0);
        if (wr0 && f0 && !ra0) m0_ovf = 1'b1; else if (clr0) m0_ovf = 1'b0;
        if (rd0 && e0) m0_udf = 1'b1; else if (clr0) m0_udf = 1'b0;

        e1  = !m1_vis(edge_n - 1);
        f1  = (exp_q1.size() == DEPTH);
        ra1 = rd1 && !e1;
        wa1 = wr1 && (!f1 || ra1);
        if (ra1) begin
            ent = exp_q1.pop_front();
            last_pop1 = edge_n;
        end
        if (wa1) begin
            ent.d = wd1;
            ent.w = edge_n;
            exp_q1.push_back(ent);
        end
        if (wr1 && f1 && !ra1) m1_ovf = 1'b1; else if (clr1) m1_ovf = 1'b0;
        if (rd1 && e1) m1_udf = 1'b1; else if (clr1) m1_udf = 1'b0;
    endtask

    task automatic compare_all();
        chk("cnt0",    64'(cnt0),   64'(exp_q0.size()));
        chk("empty0",  64'(empty0), 64'(exp_q0.size() == 0));
        chk("full0",   64'(full0),  64'(exp_q0.size() == DEPTH));
        chk("afull0",  64'(af0),    64'(exp_q0.size() >= AF));
        chk("aempty0", 64'(ae0),    64'(exp_q0.size() <= AE));
        chk("ovf0",    64'(ovf0),   64'(m0_ovf));
        chk("udf0",    64'(udf0),   64'(m0_udf));
        chk("rdata0",  64'(rdata0), 64'(exp_rdata0));
        chk("cnt1",    64'(cnt1),   64'(exp_q1.size()));
        chk("empty1",  64'(empty1), 64'(!m1_vis(edge_n)));
        chk("full1",   64'(full1),  64'(exp_q1.size() == DEPTH));
        chk("afull1",  64'(af1),    64'(exp_q1.size() >= AF));
        chk("aempty1", 64'(ae1),    64'(exp_q1.size() <= AE));
        chk("ovf1",    64'(ovf1),   64'(m1_ovf));
        chk("udf1",    64'(udf1),   64'(m1_udf));
        if (m1_vis(edge_n)) chk("rdata1", 64'(rdata1), 64'(exp_q1[0].d));
    endtask

    // driver: inputs are set just after an edge, sampled at the next one
    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rst_checks();
        chk("rst_rdata0", 64'(rdata0), 64'(0));
        chk("rst_cnt0",   64'(cnt0),   64'(0));
        chk("rst_flags0", 64'({empty0, full0, ae0, af0, ovf0, udf0}), 64'(6'b101000));
        chk("rst_rdata1", 64'(rdata1), 64'(0));
        chk("rst_cnt1",   64'(cnt1),   64'(0));
        chk("rst_flags1", 64'({empty1, full1, ae1, af1, ovf1, udf1}), 64'(6'b101000));
    endtask

    task automatic do_reset();
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
        wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        rst_checks();
        @(posedge i_clk);
        exp_q0.delete();
        exp_q1.delete();
        exp_rdata0 = '0;
        pend0 = 1'b0; m0_ovf = 1'b0; m0_udf = 1'b0;
        m1_ovf = 1'b0; m1_udf = 1'b0; last_pop1 = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 48'h1,  1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 48'h0};
        tbl[1]  = '{1'b1, 48'h2,  1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 48'h0};
        tbl[2]  = '{1'b1, 48'h3,  1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 48'h0};
        tbl[3]  = '{1'b0, 48'h0,  1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 48'h0};
        tbl[4]  = '{1'b0, 48'h0,  1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 48'h1};
        tbl[5]  = '{1'b0, 48'h0,  1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 48'h2};
        tbl[6]  = '{1'b0, 48'h0,  1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 48'h3};
        tbl[7]  = '{1'b0, 48'h0,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 48'h3};
        tbl[8]  = '{1'b0, 48'h0,  1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 48'h3};
        tbl[9]  = '{1'b0, 48'h0,  1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 48'h3};
        tbl[10] = '{1'b0, 48'h0,  1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1, 48'h3};
        tbl[11] = '{1'b0, 48'h0,  1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 48'h3};
        tbl[12] = '{1'b1, 48'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 48'h3};
        tbl[13] = '{1'b0, 48'h0,  1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 48'h3};
        tbl[14] = '{1'b0, 48'h0,  1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 48'h55};

        do_reset();

        // standard mode: table of basic reads, latency, underflow and clear priority
        for (int i = 0; i < 15; i++) begin
            wr0 = tbl[i].wr; wd0 = tbl[i].wd; rd0 = tbl[i].rd; clr0 = tbl[i].clr;
            tick();
            chk("tbl_cnt",   64'(cnt0),   64'(tbl[i].cnt));
            chk("tbl_empty", 64'(empty0), 64'(tbl[i].empty));
            chk("tbl_udf",   64'(udf0),   64'(tbl[i].udf));
            if (tbl[i].chk_rd) chk("tbl_rdata", 64'(rdata0), 64'(tbl[i].rdata));
        end
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;

        // FWFT: write-to-visible latency, then burst read at one word per clock
        wr1 = 1'b1; wd1 = 48'hAB;
        tick();
        wr1 = 1'b0;
        chk("fwft_k_empty", 64'(empty1), 64'(1));
        tick();
        chk("fwft_k1_empty", 64'(empty1), 64'(1));
        tick();
        chk("fwft_k2_empty", 64'(empty1), 64'(0));
        chk("fwft_k2_rdata", 64'(rdata1), 64'(48'hAB));
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        chk("fwft_pop_empty", 64'(empty1), 64'(1));
        for (int i = 0; i < 10; i++) begin
            wr1 = 1'b1; wd1 = WD'(512 + i);
            tick();
        end
        wr1 = 1'b0;
        tick();
        tick();
        chk("fwft_head", 64'(rdata1), 64'(512));
        for (int i = 0; i < 10; i++) begin
            rd1 = 1'b1;
            tick();
            chk("fwft_burst_cnt", 64'(cnt1), 64'(9 - i));
            if (i < 9) begin
                chk("fwft_burst_rdata", 64'(rdata1), 64'(513 + i));
                chk("fwft_burst_empty", 64'(empty1), 64'(0));
            end else begin
                chk("fwft_burst_end", 64'(empty1), 64'(1));
            end
        end
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        chk("fwft_udf", 64'(udf1), 64'(1));
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("fwft_udf_clr", 64'(udf1), 64'(0));

        // fill both to full, overflow, then rd+wr across pointer wrap, then drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr0 = 1'b1; wd0 = WD'(4096 + i);
            wr1 = 1'b1; wd1 = WD'(8192 + i);
            tick();
            chk("fill_afull0", 64'(af0), 64'((i + 1) >= AF));
            chk("fill_afull1", 64'(af1), 64'((i + 1) >= AF));
        end
        chk("fill_full0", 64'({full0, cnt0}), 64'({1'b1, 9'd256}));
        chk("fill_full1", 64'({full1, cnt1}), 64'({1'b1, 9'd256}));
        wd0 = 48'hBAD; wd1 = 48'hBAD;
        tick();
        chk("ovf0_set", 64'({ovf0, cnt0}), 64'({1'b1, 9'd256}));
        chk("ovf1_set", 64'({ovf1, cnt1}), 64'({1'b1, 9'd256}));
        wr0 = 1'b0; wr1 = 1'b0; clr0 = 1'b1; clr1 = 1'b1;
        tick();
        clr0 = 1'b0; clr1 = 1'b0;
        chk("ovf0_clr", 64'(ovf0), 64'(0));
        for (int i = 0; i < 300; i++) begin
            wr0 = 1'b1; rd0 = 1'b1; wd0 = rnd_data();
            wr1 = 1'b1; rd1 = 1'b1; wd1 = rnd_data();
            tick();
            chk("rw_full_cnt0", 64'(cnt0), 64'(256));
            chk("rw_full_cnt1", 64'(cnt1), 64'(256));
        end
        wr0 = 1'b0; wr1 = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) tick();
        rd0 = 1'b0; rd1 = 1'b0;
        tick();

        // randomized traffic in alternating fill / drain phases
        for (int c = 0; c < 2400; c++) begin
            int wp, rp;
            wp = ((c / 300) % 2 == 0) ? 90 : 25;
            rp = ((c / 300) % 2 == 0) ? 25 : 90;
            wr0 = int'($urandom_range(0, 99)) < wp; wd0 = rnd_data();
            rd0 = int'($urandom_range(0, 99)) < rp;
            clr0 = ($urandom_range(0, 49) == 0);
            wr1 = int'($urandom_range(0, 99)) < wp; wd1 = rnd_data();
            rd1 = int'($urandom_range(0, 99)) < rp;
            clr1 = ($urandom_range(0, 49) == 0);
            tick();
        end

        // asynchronous reset mid-fill discards stored data
        do_reset();
        for (int i = 0; i < 100; i++) begin
            wr0 = 1'b1; wd0 = rnd_data();
            wr1 = 1'b1; wd1 = rnd_data();
            tick();
        end
        wr0 = 1'b0; wr1 = 1'b0;
        chk("midfill_cnt0", 64'(cnt0), 64'(100));
        chk("midfill_cnt1", 64'(cnt1), 64'(100));
        i_rst = 1'b1;
        #2;
        rst_checks();
        do_reset();
        wr0 = 1'b1; wd0 = 48'hD0;
        wr1 = 1'b1; wd1 = 48'hD1;
        tick();
        wr0 = 1'b0; wr1 = 1'b0;
        tick();
        tick();
        chk("post_rst_head1", 64'(rdata1), 64'(48'hD1));
        rd0 = 1'b1; rd1 = 1'b1;
        tick();
        rd0 = 1'b0; rd1 = 1'b0;
        tick();
        chk("post_rst_rdata0", 64'(rdata0), 64'(48'hD0));
        chk("post_rst_empty", 64'({empty0, empty1}), 64'(2'b11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
